// File: rtl/card_pkg.sv
// card_pkg: shared card-code constants, FSM encoding and the shuffle index helper.
package card_pkg;
  localparam int CARD_W = 6;
  localparam int DECK_SIZE = 52;
  localparam int RANKS = 13;
  localparam int SUITS = 4;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  typedef enum logic [2:0] {IDLE, FILL, SHUFFLE, DEAL, EMPTY} state_t;
  // Scales a 16-bit random value into 0..i: top 6 bits of r*(i+1).
  function automatic logic [CARD_W-1:0] pick(input logic [15:0] r, input logic [CARD_W-1:0] i);
    logic [21:0] p;
    p = 22'(r) * 22'(i + 6'd1);
    return p[21:16];
  endfunction
endpackage

// File: rtl/card_lfsr16.sv
// card_lfsr16: free-running 16-bit Galois LFSR (right shift, mask LFSR_MASK).
// Ports: clk, rst (async, active-high, loads SEED), q = current LFSR state.
module card_lfsr16
  import card_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= SEED;
    else q <= (q >> 1) ^ (q[0] ? LFSR_MASK : 16'h0);
endmodule

// File: rtl/card_dealer.sv
// card_dealer: 52-card deck, LFSR Fisher-Yates shuffle on request, valid/ready dealing.
// Ports: clk, rst (async, active-high), shuffle_req (pulse), card_ready (consumer accept),
//        card_valid, card_bit (0..51), cards_left (0..52), busy (fill/shuffle), deck_empty.
module card_dealer
  import card_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shuffle_req,
  input  logic              card_ready,
  output logic              card_valid,
  output logic [CARD_W-1:0] card_bit,
  output logic [CARD_W-1:0] cards_left,
  output logic              busy,
  output logic              deck_empty
);
  state_t state, nxt;
  logic [15:0] lfsr;
  logic [CARD_W-1:0] deck [DECK_SIZE];
  logic [CARD_W-1:0] ptr, i, j;
  logic xfer;

  card_lfsr16 #(.SEED(SEED)) u_lfsr (.clk(clk), .rst(rst), .q(lfsr));

  assign j = pick(lfsr, i);
  assign xfer = card_valid && card_ready;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE, EMPTY: nxt = shuffle_req ? FILL : state;
      FILL:        nxt = SHUFFLE;
      SHUFFLE:     nxt = (i == 6'd1) ? DEAL : SHUFFLE;
      // A request while dealing abandons the remaining cards; any same-cycle transfer still counts.
      DEAL:        nxt = shuffle_req ? FILL : (xfer && cards_left == 6'd1) ? EMPTY : DEAL;
      default:     nxt = IDLE;
    endcase
  end

  always_comb begin
    card_valid = state == DEAL;
    deck_empty = state != DEAL;
    busy = state == FILL || state == SHUFFLE;
    card_bit = card_valid ? deck[ptr] : '0;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= '0;
      i <= '0;
      cards_left <= '0;
      for (int k = 0; k < DECK_SIZE; k++) deck[k] <= CARD_W'(k);
    end else begin
      case (state)
        FILL: begin
          i <= CARD_W'(DECK_SIZE - 1);
          for (int k = 0; k < DECK_SIZE; k++) deck[k] <= CARD_W'(k);
        end
        SHUFFLE: begin
          // Swap via non-blocking reads of the old values; j == i rewrites the same card.
          i <= i - 6'd1;
          deck[i] <= deck[j];
          deck[j] <= deck[i];
          if (i == 6'd1) begin
            ptr <= '0;
            cards_left <= CARD_W'(DECK_SIZE);
          end
        end
        DEAL:
          if (shuffle_req) cards_left <= '0;
          else if (xfer) begin
            ptr <= ptr + 6'd1;
            cards_left <= cards_left - 6'd1;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed tests of card_dealer against a queue-based deck model.
module tb_card_dealer;
  import card_pkg::*;
  logic clk = 0, rst = 1, shuffle_req = 0, card_ready = 0;
  logic card_valid, busy, deck_empty;
  logic [5:0] card_bit, cards_left;
  int total = 0, bad = 0;

  card_dealer #(.SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .shuffle_req(shuffle_req), .card_ready(card_ready),
    .card_valid(card_valid), .card_bit(card_bit), .cards_left(cards_left),
    .busy(busy), .deck_empty(deck_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, a, e, $time);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int jdx(input logic [15:0] r, input int i);
    return (int'(r) * (i + 1)) / 65536;
  endfunction

  int pend[52];
  // Whole shuffle from the LFSR value seen on the request edge: one fill step, then i=51..1.
  task automatic mk_deck(input logic [15:0] l0);
    logic [15:0] l;
    int j, t;
    l = step(step(l0));
    for (int k = 0; k < 52; k++) pend[k] = k;
    for (int i = 51; i >= 1; i--) begin
      j = jdx(l, i);
      t = pend[i]; pend[i] = pend[j]; pend[j] = t;
      l = step(l);
    end
  endtask

  logic [15:0] m_lfsr;
  int q[$];
  int busy_left;
  logic ev;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr = 16'hACE1;
      q.delete();
      busy_left = 0;
    end else begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) for (int k = 0; k < 52; k++) q.push_back(pend[k]);
      end else if (shuffle_req) begin
        q.delete();
        mk_deck(m_lfsr);
        busy_left = 52;
      end else if (q.size() > 0 && card_ready) void'(q.pop_front());
      m_lfsr = step(m_lfsr);
    end
  end

  always @(negedge clk) if (!rst) begin
    ev = busy_left == 0 && q.size() > 0;
    chk("valid", card_valid, ev);
    chk("busy", busy, busy_left > 0);
    chk("empty", deck_empty, !ev);
    chk("card", card_bit, ev ? q[0] : 0);
    if (busy_left == 0) chk("left", cards_left, q.size());
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_req;
    shuffle_req = 1;
    tick;
    shuffle_req = 0;
  endtask

  task automatic wait_valid(output int cyc, output int nb);
    cyc = 0; nb = 0;
    while (!card_valid && cyc < 200) begin
      if (busy) nb++;
      tick;
      cyc++;
    end
  endtask

  int got[$];
  int dcyc;
  task automatic deal_all(input int duty, input int max_n);
    got.delete();
    dcyc = 0;
    while (got.size() < max_n && dcyc < 3000) begin
      card_ready = $urandom_range(0, 99) < duty;
      if (card_valid && card_ready) got.push_back(int'(card_bit));
      tick;
      dcyc++;
    end
    card_ready = 0;
  endtask

  task automatic chk_perm(input string n);
    logic [51:0] seen;
    int ok;
    seen = '0;
    ok = got.size() == 52;
    foreach (got[k]) begin
      if (got[k] > 51 || seen[got[k]]) ok = 0;
      else seen[got[k]] = 1'b1;
    end
    chk(n, ok, 1);
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_valid"}, card_valid, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_empty"}, deck_empty, 1);
    chk({n, "_left"}, cards_left, 0);
    chk({n, "_card"}, card_bit, 0);
  endtask

  int cyc, nb, diff;
  int seq_a[$];

  initial begin
    tick; tick;
    chk_reset("rst");
    chk("pin_step", step(16'hACE1), 16'hE270);
    chk("pin_jmax", jdx(16'hFFFF, 51), 51);
    chk("pin_jmin", jdx(16'h0000, 51), 0);
    chk("pin_jmid", jdx(16'h8000, 51), 26);
    rst = 0;
    // Full deal with ready held high
    repeat (5) tick;
    pulse_req;
    wait_valid(cyc, nb);
    chk("t2_latency", cyc, 52);
    chk("t2_busy_cycles", nb, 52);
    chk("t2_left_start", cards_left, 52);
    deal_all(100, 52);
    chk("t2_deal_cycles", dcyc, 52);
    chk_perm("t2_perm");
    seq_a = got;
    chk("t2_end_empty", deck_empty, 1);
    chk("t2_end_left", cards_left, 0);
    // Request one cycle later after a fresh reset
    rst = 1; tick; rst = 0;
    repeat (6) tick;
    pulse_req;
    wait_valid(cyc, nb);
    chk("t4_latency", cyc, 52);
    deal_all(100, 52);
    chk_perm("t4_perm");
    diff = 0;
    foreach (got[k]) if (got[k] != seq_a[k]) diff = 1;
    chk("t4_seq_differs", diff, 1);
    // Sparse ready
    pulse_req;
    wait_valid(cyc, nb);
    chk("t3_latency", cyc, 52);
    deal_all(30, 52);
    chk_perm("t3_perm");
    chk("t3_end_left", cards_left, 0);
    // Reshuffle after 10 cards, request coincides with a transfer
    pulse_req;
    wait_valid(cyc, nb);
    deal_all(100, 10);
    card_ready = 1; shuffle_req = 1;
    tick;
    card_ready = 0; shuffle_req = 0;
    chk("t5_valid_drop", card_valid, 0);
    chk("t5_busy", busy, 1);
    wait_valid(cyc, nb);
    chk("t5_latency", cyc, 52);
    chk("t5_left", cards_left, 52);
    deal_all(100, 52);
    chk_perm("t5_perm");
    // Request during shuffle is ignored
    pulse_req;
    repeat (10) tick;
    pulse_req;
    wait_valid(cyc, nb);
    chk("t6_latency", cyc + 11, 52);
    deal_all(100, 52);
    chk_perm("t6_perm");
    // Async reset mid-shuffle
    pulse_req;
    repeat (20) tick;
    rst = 1;
    #1;
    chk_reset("t6_async");
    tick;
    rst = 0;
    pulse_req;
    wait_valid(cyc, nb);
    chk("t6_after_rst_latency", cyc, 52);
    deal_all(100, 52);
    chk_perm("t6_after_rst_perm");
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
